// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: signal bundle between the hazard sequencer and the datapath latches
interface pipeline_hazard_ctrl_if #(
    parameter int REGW = 5,
    parameter int CNTW = 32
);
    logic ihit, dhit, dmemREN_mem, dmemWEN_mem, halt_wb, memread_ex;
    logic [REGW-1:0] rt_ex, rs_id, rt_id;
    logic rt_used_id, branch_taken_ex, jr_ex, jump_id;
    logic pc_en;
    logic [1:0] pc_sel;
    logic ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted;
    logic [CNTW-1:0] stall_cycles, flush_count;
    modport master (
        output ihit, dhit, dmemREN_mem, dmemWEN_mem, halt_wb, memread_ex, rt_ex, rs_id, rt_id,
               rt_used_id, branch_taken_ex, jr_ex, jump_id,
        input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               halted, stall_cycles, flush_count
    );
    modport slave (
        input  ihit, dhit, dmemREN_mem, dmemWEN_mem, halt_wb, memread_ex, rt_ex, rs_id, rt_id,
               rt_used_id, branch_taken_ex, jr_ex, jump_id,
        output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               halted, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: advance/stall/flush sequencer for the pipeline latches; PERF_CNT_EN adds stall/flush counters
module pipeline_hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input logic CLK,
    input logic nRST,
    pipeline_hazard_ctrl_if.slave hif
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, next_state;
    logic ipend, dpend, mem_req, iok, dok, run, adv, redirect, load_use, bubble, ifid_fl, idex_fl;
    assign run = nRST && state == RUN;
    assign mem_req = hif.dmemREN_mem | hif.dmemWEN_mem;
    assign iok = hif.ihit | ipend;
    assign dok = !mem_req | hif.dhit | dpend;
    assign adv = run & iok & dok;
    assign redirect = hif.branch_taken_ex | hif.jr_ex;
    assign load_use = hif.memread_ex & (hif.rt_ex != REGW'(0)) &
                      ((hif.rt_ex == hif.rs_id) | (hif.rt_used_id & (hif.rt_ex == hif.rt_id)));
    assign bubble = adv & !redirect & load_use;
    assign ifid_fl = adv & (redirect | (!load_use & hif.jump_id));
    assign idex_fl = adv & (redirect | load_use);
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state <= RUN;
        else state <= next_state;
    always_comb next_state = (state == RUN && hif.halt_wb) ? HALT : state;
    always_comb begin
        hif.pc_en = adv & !bubble;
        hif.pc_sel = !adv ? 2'b00 : redirect ? 2'b01 : (!load_use && hif.jump_id) ? 2'b10 : 2'b00;
        hif.ifid_en = adv & !bubble;
        hif.idex_en = adv;
        hif.exmem_en = adv;
        hif.memwb_en = adv & !hif.halt_wb;
        hif.ifid_flush = ifid_fl;
        hif.idex_flush = idex_fl;
        hif.halted = nRST && state == HALT;
    end
    // a hit seen while the other side is still waiting is remembered until the pipeline advances
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            ipend <= 1'b0;
            dpend <= 1'b0;
        end else if (state == RUN) begin
            ipend <= adv ? 1'b0 : ipend | hif.ihit;
            dpend <= adv ? 1'b0 : dpend | (hif.dhit & mem_req);
        end
`ifdef PERF_CNT_EN
    logic [CNTW-1:0] stall_q, flush_q;
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (state == RUN) begin
            if ((!adv | bubble) && stall_q != '1) stall_q <= stall_q + CNTW'(1);
            if ((ifid_fl | idex_fl) && flush_q != '1) flush_q <= flush_q + CNTW'(1);
        end
    assign hif.stall_cycles = stall_q;
    assign hif.flush_count = flush_q;
`else
    assign hif.stall_cycles = CNTW'(0);
    assign hif.flush_count = CNTW'(0);
`endif
endmodule
